// File: rtl/bk_spi_pkg.sv
// rtl/bk_spi_pkg.sv - shared types, defaults and idle levels for the SPI master
package bk_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } bk_spi_state_e;

    localparam int DIV_DEF      = 4;
    localparam int CS_IDLE_DEF  = 64;
    localparam int SLOW_DIV_DEF = 100;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bk_spi_tick.sv
// rtl/bk_spi_tick.sv - half-period down-counter emitting one-cycle ticks
module bk_spi_tick
    import bk_spi_pkg::*;
#(
    parameter int DIV      = DIV_DEF,
    parameter int SLOW_DIV = SLOW_DIV_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic slow_i,
    output logic tick_o
);

    localparam int CW = $clog2(max_int(DIV, SLOW_DIV)) + 1;
    localparam logic [CW-1:0] FAST_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] SLOW_LOAD = CW'(SLOW_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          slow_q, slow_d;

    // Tick fires on the last cycle of each half-period.
    assign tick_o = (cnt_q == '0);

    // Reload on clear (latching the speed select) or at half-period end, else count down.
    always_comb begin
        slow_d = slow_q;
        cnt_d  = cnt_q - 1'b1;
        if (clear_i) begin
            slow_d = slow_i;
            cnt_d  = slow_i ? SLOW_LOAD : FAST_LOAD;
        end else if (tick_o) begin
            cnt_d = slow_q ? SLOW_LOAD : FAST_LOAD;
        end
    end

    // Counter and latched speed select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= FAST_LOAD;
            slow_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            slow_q <= slow_d;
        end
    end

endmodule

// File: rtl/bk_spi_master.sv
// rtl/bk_spi_master.sv - byte-wide SPI mode-0 master with auto chip select; BK_SPI_SLOWCLK_EN adds slow port
module bk_spi_master
    import bk_spi_pkg::*;
#(
    parameter int DIV      = DIV_DEF,
    parameter int CS_IDLE  = CS_IDLE_DEF,
    parameter int SLOW_DIV = SLOW_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_wren,
    input  logic [7:0] spi_do,
    output logic [7:0] spi_di,
    output logic       spi_dsr,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
`ifdef BK_SPI_SLOWCLK_EN
    input  logic       slow,
`endif
    output logic       cs_n
);

    localparam int IW = $clog2(CS_IDLE + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(CS_IDLE - 1);

    bk_spi_state_e state_q, state_d;
    logic          sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d, dsr_q, dsr_d;
    logic [7:0]    di_q, di_d, tx_q, tx_d, rx_q, rx_d;
    logic [2:0]    bit_q, bit_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          wren_q;
    logic          start, accept, tick, slow_sel;

`ifdef BK_SPI_SLOWCLK_EN
    assign slow_sel = slow;
`else
    assign slow_sel = 1'b0;
`endif

    assign start  = spi_wren & ~wren_q;
    assign accept = start & ((state_q == IDLE) | (state_q == HOLD));

    bk_spi_tick #(
        .DIV      (DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (accept),
        .slow_i  (slow_sel),
        .tick_o  (tick)
    );

    // Next-state and output logic; starts outside IDLE/HOLD are ignored.
    always_comb begin
        state_d = state_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        dsr_d   = dsr_q;
        di_d    = di_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    dsr_d   = 1'b0;
                    tx_d    = spi_do;
                    mosi_d  = spi_do[7];
                    bit_d   = 3'd0;
                end
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], miso};
                    end else begin
                        sck_d = SCK_IDLE;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = HOLD;
                            di_d    = rx_q;
                            dsr_d   = 1'b1;
                            idle_d  = '0;
                        end else begin
                            tx_d   = {tx_q[6:0], 1'b0};
                            mosi_d = tx_q[6];
                        end
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = SHIFT;
                    dsr_d   = 1'b0;
                    tx_d    = spi_do;
                    mosi_d  = spi_do[7];
                    idle_d  = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    mosi_d  = MOSI_IDLE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sck_q   <= SCK_IDLE;
            mosi_q  <= MOSI_IDLE;
            cs_n_q  <= 1'b1;
            dsr_q   <= 1'b1;
            di_q    <= 8'hFF;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            bit_q   <= 3'd0;
            idle_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            dsr_q   <= dsr_d;
            di_q    <= di_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            idle_q  <= idle_d;
            wren_q  <= spi_wren;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign spi_dsr = dsr_q;
    assign spi_di  = di_q;

endmodule
